// File: rtl/mrd_mem_pkt.sv
// Shared definitions for the memory read-address source: controller state
// encodings, radix array type and mixed-radix digit helpers.
package mrd_mem_pkt;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SOURCE = 3'd5;

  // Element i holds radix N_i (or digit d_i when used as a digit vector).
  typedef logic [5:0][2:0] nf_arr_t;

  // Radix values 0 and 1 both mean "radix 1".
  function automatic nf_arr_t norm_radix(input nf_arr_t nf);
    nf_arr_t r;
    for (int i = 0; i < 6; i++) begin
      r[i] = (nf[i] < 3'd2) ? 3'd1 : nf[i];
    end
    return r;
  endfunction

  // Add one to a mixed-radix digit vector; digit 0 is least significant.
  function automatic nf_arr_t mr_incr(input nf_arr_t d, input nf_arr_t n);
    nf_arr_t r;
    logic    carry;
    r     = d;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (d[i] == n[i] - 3'd1) begin
          r[i] = 3'd0;
        end else begin
          r[i]  = d[i] + 3'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mrd_digitrev_cnt.sv
// One lane's mixed-radix counter: walks k = LANE, LANE+LANES, ... within a
// frame and presents the digit-reversed index rev(k) combinationally.
module mrd_digitrev_cnt
  import mrd_mem_pkt::*;
#(
  parameter int AW    = 12,
  parameter int LANES = 4,
  parameter int LANE  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          restart,
  input  logic          step,
  input  logic          last,
  input  nf_arr_t       nf,
  output logic [AW-1:0] rev
);

  nf_arr_t q;
  nf_arr_t init;
  nf_arr_t cur;
  nf_arr_t adv;

  always_comb begin
    init = '0;
    for (int i = 0; i < LANE; i++) init = mr_incr(init, nf);
    cur = restart ? init : q;
    adv = cur;
    for (int i = 0; i < LANES; i++) adv = mr_incr(adv, nf);
  end

  // rev = d5 + N5*(d4 + N4*(... + N1*d0))
  always_comb begin
    rev = AW'(cur[0]);
    for (int i = 1; i < 6; i++) rev = AW'(cur[i]) + AW'(nf[i]) * rev;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) q <= '0;
    else if (step)     q <= last ? init : adv;
    else if (restart)  q <= init;
  end

endmodule

// File: rtl/mrd_source_gen.sv
// SOURCE-state generator: digit-reversed read addresses for LANES lanes per
// beat, followed by frame-aligned output framing and a run-complete pulse.
module mrd_source_gen
  import mrd_mem_pkt::*;
#(
  parameter int         LANES      = 4,
  parameter int         AW         = 12,
  parameter int         WAIT_START = 4,
  parameter int         SOP_DLY    = 12,
  parameter logic [2:0] SRC_CODE   = ST_SOURCE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 fsm,
  input  logic [AW-1:0]              dftpts,
  input  nf_arr_t                    Nf,
  input  logic [7:0]                 frames,
  output logic [LANES-1:0][AW-1:0]   addrs,
  output logic                       addr_valid,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic                       out_valid,
  output logic                       source_end,
  output logic                       cfg_err
);

  localparam int CW = AW + 10;
  localparam int LG = $clog2(LANES);

  logic                     in_src, in_src_q, first;
  logic [CW-1:0]            cnt;
  logic [AW-1:0]            dft_q, dft_e, l_e;
  nf_arr_t                  nf_q, nf_e;
  logic [7:0]               frm_q, frm_e, f_e;
  logic [CW-1:0]            total;
  logic [31:0]              prod;
  logic                     bad, err_now, run;
  logic                     a_win, o_win, end_hit, a_last, o_last;
  logic [AW-1:0]            a_pos, o_pos;
  logic [LANES-1:0][AW-1:0] rev_all;

  assign in_src = (fsm == SRC_CODE);
  assign first  = in_src && !in_src_q;

  // Configuration is taken live on the entry cycle, from the latch afterwards.
  assign dft_e = first ? dftpts : dft_q;
  assign frm_e = first ? frames : frm_q;
  assign nf_e  = norm_radix(first ? Nf : nf_q);
  assign l_e   = dft_e >> LG;
  assign f_e   = (frm_e == 8'd0) ? 8'd1 : frm_e;
  assign total = CW'(f_e) * CW'(l_e);

  always_comb begin
    prod = 32'd1;
    for (int i = 0; i < 6; i++) prod = prod * 32'(nf_e[i]);
  end

  assign bad     = ((dft_e & AW'(LANES - 1)) != '0) || (32'(dft_e) != prod);
  assign err_now = first ? bad : cfg_err;
  assign run     = in_src && !err_now;

  assign a_win   = run && (cnt >= CW'(WAIT_START)) && (cnt < CW'(WAIT_START) + total);
  assign o_win   = run && (cnt >= CW'(SOP_DLY)) && (cnt < CW'(SOP_DLY) + total);
  assign end_hit = run && (cnt == CW'(SOP_DLY) + total);
  assign a_last  = (a_pos == l_e - AW'(1));
  assign o_last  = (o_pos == l_e - AW'(1));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mrd_digitrev_cnt #(
      .AW    (AW),
      .LANES (LANES),
      .LANE  (g)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (!in_src),
      .restart (first),
      .step    (a_win),
      .last    (a_last),
      .nf      (nf_e),
      .rev     (rev_all[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_src_q   <= 1'b0;
      cnt        <= '0;
      dft_q      <= '0;
      nf_q       <= '0;
      frm_q      <= '0;
      a_pos      <= '0;
      o_pos      <= '0;
      addrs      <= '0;
      addr_valid <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_valid  <= 1'b0;
      source_end <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      in_src_q <= in_src;
      if (!in_src) begin
        cnt        <= '0;
        a_pos      <= '0;
        o_pos      <= '0;
        addr_valid <= 1'b0;
        out_sop    <= 1'b0;
        out_eop    <= 1'b0;
        out_valid  <= 1'b0;
        source_end <= 1'b0;
        cfg_err    <= 1'b0;
      end else begin
        if (first) begin
          dft_q <= dftpts;
          nf_q  <= Nf;
          frm_q <= frames;
        end
        cnt        <= (&cnt) ? cnt : cnt + CW'(1);
        cfg_err    <= err_now;
        addr_valid <= a_win;
        if (a_win) begin
          addrs <= rev_all;
          a_pos <= a_last ? '0 : a_pos + AW'(1);
        end
        out_sop    <= o_win && (o_pos == '0);
        out_eop    <= o_win && o_last;
        out_valid  <= o_win;
        source_end <= end_hit;
        if (o_win) o_pos <= o_last ? '0 : o_pos + AW'(1);
      end
    end
  end

endmodule
